// File: rtl/umd_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide sequencing controller.
package umd_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } umd_op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_ITER = 2'd1,
      DIV_FIX  = 2'd2,
      DONE     = 2'd3
   } umd_state_e;

   function automatic logic is_div_op(input umd_op_e op);
      return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
   endfunction

   function automatic logic is_signed_div(input umd_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic returns_rem(input umd_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/umd_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module umd_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_next_o,
   output logic [W-1:0] q_next_o
);

   logic [W:0] shifted;
   logic [W:0] diff;
   logic       fits;

   // The shifted partial remainder needs one extra bit before the trial subtract.
   assign shifted = {rem_i, q_i[W-1]};
   assign diff    = shifted - {1'b0, divisor_i};
   assign fits    = (shifted >= {1'b0, divisor_i});

   assign rem_next_o = fits ? diff[W-1:0] : shifted[W-1:0];
   assign q_next_o   = {q_i[W-2:0], fits};

endmodule

// File: rtl/umd_ctrl.sv
// RV32M multiply/divide sequencer: single-cycle multiply, iterative restoring divide.
// Optional macro UMD_CTRL_FAST_DIV_EN short-circuits divide-by-zero and signed overflow.
//
// state    | meaning
// IDLE     | ready for a request; multiplies resolve here in one cycle
// DIV_ITER | one restoring step per cycle, W steps
// DIV_FIX  | apply latched signs, select quotient or remainder
// DONE     | result held until consumed or killed
module umd_ctrl
   import umd_pkg::*;
#(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [2:0]           operator_i,
   input  logic [WORD_SIZE-1:0] operand_a_i,
   input  logic [WORD_SIZE-1:0] operand_b_i,
   input  logic                 kill_i,
   output logic                 result_valid_o,
   input  logic                 result_ready_i,
   output logic [WORD_SIZE-1:0] result_o,
   output logic                 busy_o
);

   localparam int W  = WORD_SIZE;
   localparam int CW = $clog2(W + 1);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   umd_state_e     state_q, state_d;
   umd_op_e        op_q, op_d, op_in;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
   logic           qneg_q, qneg_d, rneg_q, rneg_d;

   logic [W-1:0]   rem_step, quo_step, rem_fix, quo_fix;
   logic [2*W-1:0] a_ext, b_ext, prod;
   logic           a_sgn, b_sgn, a_neg, b_neg, sdiv;
   logic           fast_hit;
   logic [W-1:0]   fast_res;

   assign op_in = umd_op_e'(operator_i);

   assign a_sgn = (op_in != MULHU);
   assign b_sgn = (op_in == MUL) || (op_in == MULH);
   assign a_ext = {{W{a_sgn & operand_a_i[W-1]}}, operand_a_i};
   assign b_ext = {{W{b_sgn & operand_b_i[W-1]}}, operand_b_i};
   assign prod  = a_ext * b_ext;

   assign sdiv  = is_signed_div(op_in);
   assign a_neg = sdiv & operand_a_i[W-1];
   assign b_neg = sdiv & operand_b_i[W-1];

   assign rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
   assign quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;

`ifdef UMD_CTRL_FAST_DIV_EN
   logic div0, ovf;
   assign div0     = (operand_b_i == '0);
   assign ovf      = sdiv && (operand_a_i == MIN_VAL) && (operand_b_i == '1);
   assign fast_hit = div0 || ovf;
   assign fast_res = returns_rem(op_in) ? (div0 ? operand_a_i : '0)
                                        : (div0 ? '1 : MIN_VAL);
`else
   assign fast_hit = 1'b0;
   assign fast_res = '0;
`endif

   umd_div_step #(.W(W)) u_step (
      .rem_i      (rem_q),
      .q_i        (quo_q),
      .divisor_i  (dvs_q),
      .rem_next_o (rem_step),
      .q_next_o   (quo_step)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      if (kill_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  op_d = op_in;
                  if (!is_div_op(op_in)) begin
                     result_d = (op_in == MUL) ? prod[W-1:0] : prod[2*W-1:W];
                     state_d  = DONE;
                  end else if (fast_hit) begin
                     result_d = fast_res;
                     state_d  = DONE;
                  end else begin
                     quo_d  = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
                     dvs_d  = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
                     // A zero divisor must yield all ones, so never negate that quotient.
                     qneg_d = (a_neg ^ b_neg) && (operand_b_i != '0);
                     rneg_d = a_neg;
                     rem_d  = '0;
                     cnt_d  = CW'(W);
                     state_d = DIV_ITER;
                  end
               end
            end
            DIV_ITER: begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = DIV_FIX;
            end
            DIV_FIX: begin
               result_d = returns_rem(op_q) ? rem_fix : quo_fix;
               state_d  = DONE;
            end
            DONE: begin
               if (result_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign req_ready_o    = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign result_valid_o = (state_q == DONE);
   assign result_o       = result_q;

endmodule

// File: tb/tb_umd_ctrl.sv
// Bench for umd_ctrl: directed test-plan cases plus random traffic against an arithmetic reference model.
module tb_umd_ctrl;
   import umd_pkg::*;

   localparam int W = 32;
`ifdef UMD_CTRL_FAST_DIV_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [2:0]    operator_i = 3'd0;
   logic [W-1:0]  operand_a_i = '0;
   logic [W-1:0]  operand_b_i = '0;
   logic          kill_i = 1'b0;
   logic          result_valid_o;
   logic          result_ready_i = 1'b0;
   logic [W-1:0]  result_o;
   logic          busy_o;

   always #5 clk = ~clk;

   umd_ctrl #(.WORD_SIZE(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .operator_i     (operator_i),
      .operand_a_i    (operand_a_i),
      .operand_b_i    (operand_b_i),
      .kill_i         (kill_i),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .busy_o         (busy_o)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // RISC-V M-extension results from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (op)
         3'd0: begin t = sa * sb; return t[31:0];  end
         3'd1: begin t = sa * sb; return t[63:32]; end
         3'd2: begin t = sa * ub; return t[63:32]; end
         3'd3: begin t = ua * ub; return t[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            t = sa / sb; return t[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            t = ua / ub; return t[31:0];
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            t = sa % sb; return t[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            t = ua % ub; return t[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      bit special;
      if (op < 3'd4) return 1;
      special = (b == 32'd0) ||
                ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      if (FAST && special) return 1;
      return W + 2;
   endfunction

   // Transaction-level model: busy flag, cycles left until the result shows, held result.
   bit          m_busy = 1'b0;
   bit          m_valid = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_wait  = 0;
      end else if (!m_busy) begin
         if (req_valid_i && !kill_i) begin
            m_busy  = 1'b1;
            m_res   = ref_result(operator_i, operand_a_i, operand_b_i);
            m_wait  = ref_latency(operator_i, operand_a_i, operand_b_i) - 1;
            m_valid = (m_wait == 0);
         end
      end else if (kill_i) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
      end else if (m_valid) begin
         if (result_ready_i) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
         end
      end else begin
         m_wait--;
         if (m_wait == 0) m_valid = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_ready", req_ready_o, !m_busy);
         chk("cyc_busy", busy_o, m_busy);
         chk("cyc_valid", result_valid_o, m_valid);
         if (m_valid) chk("cyc_result", result_o, m_res);
      end
   end

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
      int cyc;
      @(negedge clk);
      operator_i = op; operand_a_i = a; operand_b_i = b;
      req_valid_i = 1'b1; result_ready_i = 1'b0; kill_i = 1'b0;
      @(negedge clk);
      cyc = 1;
      req_valid_i = 1'b0;
      operand_a_i = $urandom; operand_b_i = $urandom;
      chk("ready_after_accept", req_ready_o, 1'b0);
      while (!result_valid_o && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, exp_lat);
      chk("result", result_o, exp_res);
      for (int i = 0; i < hold; i++) begin
         req_valid_i = 1'b1;
         @(negedge clk);
         chk("hold_result", result_o, exp_res);
         chk("hold_ready", req_ready_o, 1'b0);
         chk("hold_valid", result_valid_o, 1'b1);
      end
      req_valid_i = 1'b0;
      result_ready_i = 1'b1;
      @(negedge clk);
      result_ready_i = 1'b0;
      chk("release_ready", req_ready_o, 1'b1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int  cyc;
      int  slow;
      bit  seen;

      slow = FAST ? 1 : W + 2;
      repeat (3) @(negedge clk);
      chk("rst_result", result_o, 32'd0);
      chk("rst_valid", result_valid_o, 1'b0);
      chk("rst_ready", req_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, 0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, W + 2, 0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, W + 2, 0);
      do_op(3'd5, 32'd100, 32'd7, 32'd14, W + 2, 0);
      do_op(3'd7, 32'd100, 32'd7, 32'd2, W + 2, 0);
      do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, slow, 0);
      do_op(3'd7, 32'd5, 32'd0, 32'd5, slow, 0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, slow, 0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, slow, 0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, slow, 0);
      do_op(3'd0, 32'd6, 32'd9, 32'd54, 1, 5);
      do_op(3'd5, 32'd1000, 32'd10, 32'd100, W + 2, 5);

      // Kill a divide at cycle 10.
      @(negedge clk);
      operator_i = 3'd4; operand_a_i = 32'd1000; operand_b_i = 32'd3; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      chk("kill_idle_busy", busy_o, 1'b0);
      chk("kill_idle_ready", req_ready_o, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid_o) seen = 1'b1;
      end
      chk("kill_never_valid", seen, 1'b0);
      do_op(3'd0, 32'd3, 32'd4, 32'd12, 1, 0);

      // Reset pulse in the middle of a divide.
      @(negedge clk);
      operator_i = 3'd5; operand_a_i = 32'd77; operand_b_i = 32'd5; req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", result_valid_o, 1'b0);
      chk("midrst_ready", req_ready_o, 1'b1);
      chk("midrst_busy", busy_o, 1'b0);
      chk("midrst_result", result_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd3, 32'd4, 32'd12, 1, 0);

      // Kill in IDLE must block the accept.
      @(negedge clk);
      operator_i = 3'd0; operand_a_i = 32'd2; operand_b_i = 32'd2;
      req_valid_i = 1'b1; kill_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0; kill_i = 1'b0;
      chk("idle_kill_blocks", req_ready_o, 1'b1);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         req_valid_i    = ($urandom_range(0, 3) != 0);
         operator_i     = 3'($urandom_range(0, 7));
         operand_a_i    = pick();
         operand_b_i    = pick();
         kill_i         = ($urandom_range(0, 40) == 0);
         result_ready_i = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      req_valid_i = 1'b0; kill_i = 1'b0; result_ready_i = 1'b1;
      repeat (40) @(negedge clk);
      chk("drain_idle", req_ready_o, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
